// File: rtl/la_wb_initiator.sv
// Wishbone classic single-cycle initiator: valid/ready command in, one bus cycle out, response back.
// Define LA_WB_INIT_ERR_EN to add the wbm_err_i input, which ends a cycle with an error response.
module la_wb_initiator #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
`ifdef LA_WB_INIT_ERR_EN
  input  logic        wbm_err_i,
`endif
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_e;

  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]   wdog_q, wdog_d;
  logic              bus_err;
  logic              wdog_expired;

`ifdef LA_WB_INIT_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    wdog_d      = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // ACK has priority over both ERR and the watchdog on the same edge.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          state_d     = S_RESP;
        end else if (bus_err || wdog_expired) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule
